// File: rtl/mux_rr_reg_if.sv
// Bundle of N valid/ready producer streams plus one registered consumer stream.
// The slave modport is the mux's view; the master modport is the view of the producers and the consumer.
interface mux_rr_reg_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic                      mode;
  logic [SEL_W-1:0]          select;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          result;
  logic                      result_valid;
  logic                      result_ready;
  logic [SEL_W-1:0]          result_channel;

  modport master (
    output mode, select, in_data, in_valid, result_ready,
    input  in_ready, result, result_valid, result_channel
  );

  modport slave (
    input  mode, select, in_data, in_valid, result_ready,
    output in_ready, result, result_valid, result_channel
  );
endinterface

// File: rtl/mux_rr_reg.sv
// Registered N:1 stream mux (select-driven or round-robin); 1-cycle latency, 1 word/cycle sustained.
// Backpressure: with the output register full and result_ready low, every in_ready bit is 0 and all state holds.
module mux_rr_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic        clock,
  input  logic        reset_n,
  mux_rr_reg_if.slave bus
);

  logic [WIDTH-1:0]    result_q, result_d;
  logic [SEL_W-1:0]    result_channel_q, result_channel_d;
  logic                result_valid_q, result_valid_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;

  logic                load;
  logic                grant_vld;
  logic [SEL_W-1:0]    grant_idx;
  logic [SEL_W:0]      cand;
  logic [CHANNELS-1:0] in_ready;

  assign load = !result_valid_q || bus.result_ready;

  // Round-robin scans ptr+1 .. ptr+CHANNELS with an explicit wrap, so
  // indices at or above CHANNELS are never formed for non-power-of-2 sizes.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!bus.mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!grant_vld && bus.select == SEL_W'(i) && bus.in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
        if (cand >= (SEL_W+1)'(CHANNELS)) begin
          cand = cand - (SEL_W+1)'(CHANNELS);
        end
        if (!grant_vld && bus.in_valid[cand[SEL_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (reset_n && load && grant_vld) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    result_d         = result_q;
    result_channel_d = result_channel_q;
    result_valid_d   = result_valid_q;
    ptr_d            = ptr_q;
    if (load) begin
      if (grant_vld) begin
        result_d         = bus.in_data[grant_idx*WIDTH +: WIDTH];
        result_channel_d = grant_idx;
        result_valid_d   = 1'b1;
        ptr_d            = grant_idx;
      end else begin
        result_valid_d   = 1'b0;
      end
    end
  end

  // ptr resets to the last channel so channel 0 wins the first round-robin scan.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q         <= '0;
      result_channel_q <= '0;
      result_valid_q   <= 1'b0;
      ptr_q            <= SEL_W'(CHANNELS - 1);
    end else begin
      result_q         <= result_d;
      result_channel_q <= result_channel_d;
      result_valid_q   <= result_valid_d;
      ptr_q            <= ptr_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.result         = result_q;
  assign bus.result_channel = result_channel_q;
  assign bus.result_valid   = result_valid_q;

  a_ready_onehot: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(in_ready));

  a_stall_holds: assert property (@(posedge clock) disable iff (!reset_n)
    (result_valid_q && !bus.result_ready) |=> (result_valid_q && $stable(result_q)
                                              && $stable(result_channel_q)));

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: a 4-channel and a 3-channel instance driven side by side,
// checked against a queue-free behavioural model of the grant/register rules.
module tb_mux_rr_reg;

  logic clock;
  logic reset_n;

  mux_rr_reg_if #(.WIDTH(32), .CHANNELS(4)) bus4 ();
  mux_rr_reg_if #(.WIDTH(32), .CHANNELS(3)) bus3 ();

  mux_rr_reg #(.WIDTH(32), .CHANNELS(4)) u_dut4 (.clock(clock), .reset_n(reset_n), .bus(bus4));
  mux_rr_reg #(.WIDTH(32), .CHANNELS(3)) u_dut3 (.clock(clock), .reset_n(reset_n), .bus(bus3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Stimulus per DUT (index 0 = 4 channels, 1 = 3 channels)
  bit          t_mode   [2];
  int          t_sel    [2];
  logic [3:0]  t_valid  [2];
  bit          t_rready [2];
  logic [31:0] t_data   [2][4];

  // Reference model state
  bit          m_rv   [2];
  logic [31:0] m_res  [2];
  int          m_ch   [2];
  int          m_ptr  [2];
  int          pend_g [2];
  logic [31:0] pend_d [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int model_grant(input int d);
    int n = nch(d);
    if (!t_mode[d]) begin
      if (t_sel[d] < n && t_valid[d][t_sel[d]]) return t_sel[d];
      return -1;
    end
    for (int k = 1; k <= n; k++) begin
      int c = (m_ptr[d] + k) % n;
      if (t_valid[d][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] obs_ready(input int d);
    return (d == 0) ? bus4.in_ready : {1'b0, bus3.in_ready};
  endfunction
  function automatic logic obs_rv(input int d);
    return (d == 0) ? bus4.result_valid : bus3.result_valid;
  endfunction
  function automatic logic [31:0] obs_res(input int d);
    return (d == 0) ? bus4.result : bus3.result;
  endfunction
  function automatic int obs_ch(input int d);
    return (d == 0) ? int'(bus4.result_channel) : int'(bus3.result_channel);
  endfunction

  task automatic drive();
    bus4.mode         = t_mode[0];
    bus4.select       = 2'(t_sel[0]);
    bus4.in_valid     = t_valid[0];
    bus4.result_ready = t_rready[0];
    for (int i = 0; i < 4; i++) bus4.in_data[i*32 +: 32] = t_data[0][i];
    bus3.mode         = t_mode[1];
    bus3.select       = 2'(t_sel[1]);
    bus3.in_valid     = t_valid[1][2:0];
    bus3.result_ready = t_rready[1];
    for (int i = 0; i < 3; i++) bus3.in_data[i*32 +: 32] = t_data[1][i];
  endtask

  task automatic set_in(input bit mode, input int sel, input logic [3:0] vld, input bit rdy);
    for (int d = 0; d < 2; d++) begin
      t_mode[d]   = mode;
      t_sel[d]    = sel;
      t_valid[d]  = vld;
      t_rready[d] = rdy;
      for (int i = 0; i < 4; i++) t_data[d][i] = 32'((cyc << 8) | (d << 4) | i);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rv[d]  = 1'b0;
      m_res[d] = '0;
      m_ch[d]  = 0;
      m_ptr[d] = nch(d) - 1;
    end
  endtask

  // One clock: drive at posedge+1, check in_ready at negedge, check outputs at next posedge+1.
  task automatic step();
    logic [3:0] exp_rdy;
    int g;
    drive();
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      g       = model_grant(d);
      exp_rdy = '0;
      if ((!m_rv[d] || t_rready[d]) && g >= 0) exp_rdy[g] = 1'b1;
      chk($sformatf("in_ready[d%0d]", d), obs_ready(d), exp_rdy);
      pend_g[d] = (!m_rv[d] || t_rready[d]) ? g : -2;
      if (g >= 0) pend_d[d] = t_data[d][g];
    end
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (pend_g[d] >= 0) begin
        m_rv[d]  = 1'b1;
        m_res[d] = pend_d[d];
        m_ch[d]  = pend_g[d];
        m_ptr[d] = pend_g[d];
      end else if (pend_g[d] == -1) begin
        m_rv[d] = 1'b0;
      end
      chk($sformatf("result_valid[d%0d]", d), obs_rv(d), m_rv[d]);
      chk($sformatf("result[d%0d]", d), obs_res(d), m_res[d]);
      chk($sformatf("result_channel[d%0d]", d), obs_ch(d), m_ch[d]);
    end
    cyc++;
  endtask

  // Entered just after a posedge; leaves just after a posedge with reset released.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid[d%0d]", d), obs_rv(d), 1'b0);
      chk($sformatf("rst_result[d%0d]", d), obs_res(d), 32'h0);
      chk($sformatf("rst_channel[d%0d]", d), obs_ch(d), 0);
    end
    set_in(1'b1, 0, 4'hF, 1'b1);
    drive();
    @(negedge clock);
    for (int d = 0; d < 2; d++) chk($sformatf("rst_in_ready[d%0d]", d), obs_ready(d), 4'h0);
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("rst_hold_valid[d%0d]", d), obs_rv(d), 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    int prev;
    reset_n = 1'b1;
    set_in(1'b0, 0, 4'h0, 1'b0);
    drive();
    @(posedge clock);
    #1;
    do_reset();

    // Round-robin fairness, all valid
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 0, 4'hF, 1'b1);
      step();
      chk("rr4_seq", obs_ch(0), i % 4);
      chk("rr3_seq", obs_ch(1), i % 3);
      chk("rr_thru", obs_rv(0), 1'b1);
    end

    // Mid-stream reset with a full output register
    chk("pre_rst_full", obs_rv(0), 1'b1);
    do_reset();
    set_in(1'b1, 0, 4'hF, 1'b1);
    step();
    chk("post_rst_first4", obs_ch(0), 0);
    chk("post_rst_first3", obs_ch(1), 0);

    // Select mode
    set_in(1'b0, 2, 4'hF, 1'b1);
    t_data[0][0] = 32'hAAAA; t_data[0][1] = 32'hBBBB;
    t_data[0][2] = 32'hCCCC; t_data[0][3] = 32'hDDDD;
    step();
    chk("sel2_result", obs_res(0), 32'hCCCC);
    chk("sel2_channel", obs_ch(0), 2);
    set_in(1'b0, 2, 4'b1011, 1'b1);
    step();
    chk("sel2_novalid_drain", obs_rv(0), 1'b0);

    // Sparse round-robin: channels 1 and 3
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 0, 4'b1010, 1'b1);
      step();
      chk("sparse_alt", (obs_ch(0) == 1 || obs_ch(0) == 3) && obs_ch(0) != prev, 1'b1);
      prev = obs_ch(0);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 0, 4'b0010, 1'b1);
      step();
      chk("single_ch1", obs_ch(0), 1);
    end

    // Backpressure while holding 0xAAAA
    set_in(1'b1, 0, 4'b0001, 1'b1);
    t_data[0][0] = 32'hAAAA;
    step();
    chk("bp_load", obs_res(0), 32'hAAAA);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 0, 4'hF, 1'b0);
      step();
      chk("bp_hold", obs_res(0), 32'hAAAA);
    end
    set_in(1'b1, 0, 4'hF, 1'b1);
    step();
    chk("bp_release_ch", obs_ch(0), 1);
    chk("bp_release_dat", obs_res(0), t_data[0][1]);

    // Out-of-range select on the 3-channel instance
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 3, 4'hF, 1'b1);
      step();
      chk("sel3_nogrant", obs_rv(1), 1'b0);
    end

    // Randomized traffic, with one reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      for (int d = 0; d < 2; d++) begin
        t_mode[d]   = ($urandom_range(0, 3) != 0);
        t_sel[d]    = $urandom_range(0, 3);
        t_valid[d]  = 4'($urandom);
        t_rready[d] = ($urandom_range(0, 9) < 7);
        for (int c = 0; c < 4; c++) t_data[d][c] = $urandom;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_rr_reg.md
# mux_rr_reg

Parametrised, registered N-channel multiplexer for the MiniMIPS datapath, the successor to the 2:1 combinational mux. It selects one of `CHANNELS` valid/ready input streams of `WIDTH` bits and delivers it through a one-entry output register with a valid/ready handshake. It runs in two modes: explicit select, or round-robin arbitration. It sits where several producers share one consumer, for example writeback sources or memory requestors.

## Interface
- `WIDTH`, 32, data width per channel.
- `CHANNELS`, 4, number of input channels, 2..16.
- `SEL_W`, `$clog2(CHANNELS)`, width of the select and channel-ID fields.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = select-driven, 1 = round-robin.
- `select`  in  SEL_W  channel index, used only when mode=0.
- `in_data`  in  CHANNELS*WIDTH  channel i occupies `[i*WIDTH +: WIDTH]`.
- `in_valid`  in  CHANNELS  per-channel valid.
- `in_ready`  out  CHANNELS  per-channel ready, one-hot or zero.
- `result`  out  WIDTH  registered output data.
- `result_valid`  out  1  the output register holds data.
- `result_ready`  in  1  the consumer accepts `result` this cycle.
- `result_channel`  out  SEL_W  index of the channel that produced `result`.

## Operation
- `load = !result_valid || result_ready`: the output register is empty or is being drained this cycle.
- Grant selection is combinational from `mode`, `select`, `in_valid` and the pointer `ptr`:
  - mode=0: grant = `select` if `select < CHANNELS` and `in_valid[select]`; otherwise no grant.
  - mode=1: grant = first channel with valid set, scanning `ptr+1, ptr+2, …` modulo CHANNELS; no grant if no channel is valid.
- `in_ready[g] = load && grant_exists`. All other `in_ready` bits are 0.
  - `in_ready` depends combinationally on `in_valid`. Upstream must not make valid depend on ready.
- Transfer on channel g: `in_valid[g] && in_ready[g]`. On the next edge:
  - `result <= in_data[g]`
  - `result_channel <= g`
  - `result_valid <= 1`
  - `ptr <= g` (in both modes)
- When `load` is 1 and there is no grant: on the next edge `result_valid <= 0`, and `result`/`result_channel` hold their values.
- When `load` is 0 (stalled): `result`, `result_channel`, `result_valid` and `ptr` all hold. Data is never overwritten or dropped.
- Drain and refill in the same cycle (`result_valid && result_ready` with a transfer) is allowed. This gives 1 word per cycle sustained.
- Arithmetic: the modulo wrap in the scan is explicit for non-power-of-2 CHANNELS. Indices at or above CHANNELS are never granted.
- A change of `mode` or `select` takes effect at the next arbitration. A word already in the output register is unaffected.

## Timing
- Latency: 1 cycle, from the input transfer edge to `result_valid` being high with the data.
- Throughput: 1 transfer per cycle when `result_ready` stays high.
- Reset (asynchronous assert, takes effect immediately):
  - `result_valid = 0`, `result = 0`, `result_channel = 0`.
  - `ptr = CHANNELS-1`, so after reset channel 0 has first priority.
- With `result_valid = 0`, `in_ready` is 0 during reset.
- Reset mid-operation: any pending output word is discarded and no handshake completes. Deassertion is synchronised externally; the first transfer happens on the first edge after release.
- Boundary cases:
  - All channels valid in mode=1: grants rotate 0,1,2,…,CHANNELS-1,0.
  - Only one channel valid: it is granted every cycle.
  - `result_ready` low while full: every `in_ready` bit is 0.

## Test plan
- **Reset:** assert `reset_n=0` mid-stream with `result_valid=1` → `result_valid`, `result` and `result_channel` all read 0 within the same cycle. After release, with all channels valid in mode=1, the first grant is channel 0.
- **Select mode (CHANNELS=4, WIDTH=32):** `in_data` = {0xDDDD, 0xCCCC, 0xBBBB, 0xAAAA}, all valid, `select=2` → the next cycle gives `result=0xCCCC`, `result_channel=2`, and only `in_ready[2]` is high. With `select=2` but `in_valid[2]=0` → no grant, and `result_valid` drops after the drain.
- **Round-robin fairness:** all 4 valid, `result_ready=1` for 8 cycles → `result_channel` sequence is 0,1,2,3,0,1,2,3 and throughput is 1 per cycle.
- **Sparse round-robin:** only channels 1 and 3 valid → the sequence alternates 1,3,1,3. Then drop channel 3 → channel 1 every cycle.
- **Backpressure:** hold `result_ready=0` for 3 cycles while full with 0xAAAA → `result` holds 0xAAAA, all `in_ready` are 0, and `ptr` is unchanged. On release, the next word follows immediately with no duplicate and no loss.
- **Non-power-of-2 (CHANNELS=3):** all valid in mode=1 → the sequence is 0,1,2,0. `select=3` in mode=0 → no grant ever.
